// File: rtl/mic_delay_sum.sv
// Delay-and-sum beamformer: CHANNELS PCM streams go into a circular sample RAM.
// Each channel is read back at its own delay and the samples are summed at full precision.
module mic_delay_sum #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 64,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(CHANNELS)
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    input  logic                          delay_we,
    input  logic [CW-1:0]                 delay_ch,
    input  logic [AW-1:0]                 delay_val,
    output logic                          out_valid,
    output logic signed [WIDTH+CW-1:0]    out_sum,
    output logic                          busy,
    output logic                          overrun
);
    localparam int SW = WIDTH + CW;
    localparam int RW = CW + AW;

    typedef enum logic [2:0] {CLEAR, IDLE, WRITE, READ, DONE} state_t;

    state_t                    state_reg;
    logic [RW-1:0]             clr_cnt_reg;
    logic [AW-1:0]             wp_reg;
    logic [CW:0]               cnt_reg;
    logic [AW-1:0]             delay_reg [CHANNELS];
    logic [AW-1:0]             snap_reg  [CHANNELS];
    logic signed [WIDTH-1:0]   data_reg  [CHANNELS];
    logic signed [SW-1:0]      acc_reg;

    logic signed [WIDTH-1:0]   in_lane [CHANNELS];
    logic signed [WIDTH-1:0]   mem [CHANNELS*DEPTH];
    logic signed [WIDTH-1:0]   rd_data_reg;
    logic signed [SW-1:0]      rd_ext;
    logic                      ram_we;
    logic [RW-1:0]             ram_waddr;
    logic [RW-1:0]             ram_raddr;
    logic signed [WIDTH-1:0]   ram_wdata;
    logic [CW-1:0]             ch_idx;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            assign in_lane[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign ch_idx = cnt_reg[CW-1:0];
    assign rd_ext = {{CW{rd_data_reg[WIDTH-1]}}, rd_data_reg};
    assign busy   = (state_reg != IDLE);

    // Single write port serves both the zero-fill sweep and frame writes
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_cnt_reg;
        ram_wdata = '0;
        ram_raddr = {ch_idx, AW'(wp_reg - snap_reg[ch_idx])};
        case (state_reg)
            CLEAR: ram_we = 1'b1;
            WRITE: begin
                ram_we    = 1'b1;
                ram_waddr = {ch_idx, wp_reg};
                ram_wdata = data_reg[ch_idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
        rd_data_reg <= mem[ram_raddr];
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            wp_reg      <= '0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            out_sum     <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            delay_reg   <= '{default: '0};
            snap_reg    <= '{default: '0};
            data_reg    <= '{default: '0};
        end else begin
            out_valid <= 1'b0;
            overrun   <= in_valid && (state_reg != IDLE);
            if (delay_we)
                delay_reg[delay_ch] <= delay_val;

            case (state_reg)
                CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (clr_cnt_reg == '1)
                        state_reg <= IDLE;
                end
                IDLE: begin
                    if (in_valid) begin
                        data_reg  <= in_lane;
                        snap_reg  <= delay_reg;
                        cnt_reg   <= '0;
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    if (cnt_reg == (CW+1)'(CHANNELS - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= READ;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                READ: begin
                    // Read data lags the issue by one cycle; the last word lands in the drain cycle
                    if (cnt_reg == (CW+1)'(CHANNELS)) begin
                        out_sum   <= acc_reg + rd_ext;
                        out_valid <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        if (cnt_reg == '0)
                            acc_reg <= '0;
                        else
                            acc_reg <= acc_reg + rd_ext;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    wp_reg    <= wp_reg + 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end
endmodule
